// File: rtl/local_field_accumulator.sv
// -----------------------------------------------------------------------------
// local_field_accumulator
//
// Purpose:
//   Computes the local field of one p-bit row in the time-multiplexed p-bit
//   core. For a requested row it triggers the CSR weight/bias loader, consumes
//   the streamed (value, index) weight beats, and forms
//       I = h + sum(value * m[index]),   m[index] in {-1,+1}
//   against a snapshot of the spin vector taken when the row was accepted.
//   It then hands I to the p-bit update stage and releases the loader.
//
// Build option:
//   FIELD_SAT_EN - when defined, the accumulator is saturated into the signed
//                  FIELD_WIDTH output range; when undefined it is truncated
//                  (two's complement wrap-around).
//
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   start, row_sel - request a field computation for row row_sel
//   m              - spin state vector (1 = +1, 0 = -1)
//   busy           - high from the accepted start through the compute_done cycle
//   start_load     - one-cycle pulse asking the loader for current_row
//   current_row    - row presented to the loader
//   data_valid     - loader beat strobe, with value/index
//   h              - signed bias, stable from load_done onward
//   row_length     - beat count the loader promises
//   load_done      - loader finished; held high until compute_done
//   compute_done   - one-cycle pulse releasing the loader
//   field          - signed local field, held until the next field_valid
//   field_row      - row that field belongs to
//   field_valid    - one-cycle pulse qualifying field/field_row
//   err            - sticky error flag (bad row, bad index, beat count mismatch)
// -----------------------------------------------------------------------------
module local_field_accumulator #(
    parameter int NUM_PBITS   = 16,
    parameter int VAL_WIDTH   = 8,
    parameter int INDEX_WIDTH = 5,
    parameter int H_WIDTH     = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int FIELD_WIDTH = 12
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [$clog2(NUM_PBITS+1)-1:0]       row_sel,
    input  logic [NUM_PBITS-1:0]                 m,
    output logic                                 busy,
    output logic                                 start_load,
    output logic [$clog2(NUM_PBITS+1)-1:0]       current_row,
    input  logic                                 data_valid,
    input  logic signed [VAL_WIDTH-1:0]          value,
    input  logic [INDEX_WIDTH-1:0]               index,
    input  logic signed [H_WIDTH-1:0]            h,
    input  logic [4:0]                           row_length,
    input  logic                                 load_done,
    output logic                                 compute_done,
    output logic signed [FIELD_WIDTH-1:0]        field,
    output logic [$clog2(NUM_PBITS+1)-1:0]       field_row,
    output logic                                 field_valid,
    output logic                                 err
);

    // Bits needed to address one spin inside the snapshot.
    localparam int SNAP_IW = $clog2(NUM_PBITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACCUM,
        S_FINAL,
        S_OUT
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [NUM_PBITS-1:0]    r_snap;      // spin vector frozen at row accept
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [5:0]              r_beats;     // one spare bit above row_length

    logic                    w_accept;
    logic                    w_bad_row;
    logic                    w_row_ok;
    logic                    w_idx_ok;
    logic                    w_snap_bit;
    logic [ACC_WIDTH-1:0]    w_value_ext;
    logic [ACC_WIDTH-1:0]    w_h_ext;
    logic [ACC_WIDTH-1:0]    w_beat_sum;
    logic [ACC_WIDTH-1:0]    w_acc_h;
    logic [FIELD_WIDTH-1:0]  w_field_next;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    assign w_row_ok    = 32'(row_sel) < NUM_PBITS;
    assign w_idx_ok    = 32'(index) < NUM_PBITS;
    // Only meaningful when w_idx_ok; out-of-range beats never touch r_acc.
    assign w_snap_bit  = r_snap[index[SNAP_IW-1:0]];

    assign w_value_ext = {{(ACC_WIDTH-VAL_WIDTH){value[VAL_WIDTH-1]}}, value};
    assign w_h_ext     = {{(ACC_WIDTH-H_WIDTH){h[H_WIDTH-1]}}, h};

    // Spin +1 adds the weight, spin -1 subtracts it.
    assign w_beat_sum  = w_snap_bit ? (r_acc + w_value_ext) : (r_acc - w_value_ext);
    assign w_acc_h     = r_acc + w_h_ext;

    // Narrowing of the final sum into the output field width.
    always_comb begin
        w_field_next = w_acc_h[FIELD_WIDTH-1:0];
`ifdef FIELD_SAT_EN
        // In range only if every bit from the field sign upward equals the
        // accumulator sign; otherwise clamp to the nearest extreme.
        if (w_acc_h[ACC_WIDTH-1:FIELD_WIDTH-1] !=
            {(ACC_WIDTH-FIELD_WIDTH+1){w_acc_h[ACC_WIDTH-1]}}) begin
            w_field_next = w_acc_h[ACC_WIDTH-1] ? {1'b1, {(FIELD_WIDTH-1){1'b0}}}
                                                : {1'b0, {(FIELD_WIDTH-1){1'b1}}};
        end
`else
        w_field_next = w_acc_h[FIELD_WIDTH-1:0];
`endif
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and output decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_bad_row    = 1'b0;
        busy         = 1'b1;
        start_load   = 1'b0;
        compute_done = 1'b0;
        field_valid  = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_row_ok) begin
                        w_accept     = 1'b1;
                        w_next_state = S_REQ;
                    end else begin
                        w_bad_row    = 1'b1;
                    end
                end
            end
            S_REQ: begin
                start_load   = 1'b1;
                w_next_state = S_ACCUM;
            end
            S_ACCUM: begin
                // A beat arriving with load_done is still accumulated by the
                // datapath before the state moves on.
                if (load_done) begin
                    w_next_state = S_FINAL;
                end
            end
            S_FINAL: begin
                w_next_state = S_OUT;
            end
            S_OUT: begin
                compute_done = 1'b1;
                field_valid  = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: snapshot, accumulator, beat counter, result and error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_snap      <= '0;
            r_acc       <= '0;
            r_beats     <= '0;
            current_row <= '0;
            field       <= '0;
            field_row   <= '0;
            err         <= 1'b0;
        end else begin
            if (w_accept) begin
                current_row <= row_sel;
                r_snap      <= m;
                r_acc       <= '0;
                r_beats     <= '0;
            end

            if (w_bad_row) begin
                err <= 1'b1;
            end

            if (r_state == S_ACCUM && data_valid) begin
                // Dropped beats still count toward the row_length check.
                r_beats <= r_beats + 6'd1;
                if (w_idx_ok) begin
                    r_acc <= w_beat_sum;
                end else begin
                    err   <= 1'b1;
                end
            end

            // The bias is added and the narrowed result registered on the
            // FINAL edge, so field/field_row are already stable while OUT
            // pulses field_valid.
            if (r_state == S_FINAL) begin
                r_acc     <= w_acc_h;
                field     <= w_field_next;
                field_row <= current_row;
                if (r_beats != {1'b0, row_length}) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
